// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer:
// sequencer states, supported opcodes and the ALU mux/operation codes.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        EXEC,
        ALU_WB,
        ADDR,
        MEM,
        LW_WB,
        BRANCH,
        HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALU_SUB   = 2'b00;
    localparam logic [1:0] ALU_ADD   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

    function automatic logic is_alu_class(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_ADDIU) || (op == OP_ORI);
    endfunction

    function automatic logic is_mem_class(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_wait_timer.sv
// Memory wait counter: counts non-ready cycles of one request and flags
// when the last permitted wait cycle has been reached.
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] count_reg;

    assign expired = (count_reg == CNT_W'(TIMEOUT - 1));

    // Saturates at the limit so a held enable can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control sequencer (R-type, addiu, ori, lw, sw; beq when
// MULTICYCLE_CONTROL_BRANCH_EN is defined) with memory timeout and retire count.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int RET_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_w,
    output logic             pc_w_cond,
    output logic             pc_src,
    output logic             iord,
    output logic             mem_r,
    output logic             mem_w,
    output logic             ir_w,
    output logic             reg_dst,
    output logic             reg_w,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal_op,
    output logic             timeout_err,
    output logic [RET_W-1:0] retired
);

    state_t           state_reg;
    state_t           state_next;
    logic             timeout_err_reg;
    logic [RET_W-1:0] retired_reg;
    logic             retire;
    logic             timeout_hit;
    logic             wait_expired;
    logic             timer_clear;
    logic             timer_en;

    // The zero flag is consumed by the datapath's (pc_w_cond & zero) gate.
    logic unused_zero;
    assign unused_zero = zero;

    // Any state change clears the wait count, so each FETCH/MEM entry starts at 0.
    assign timer_clear = (state_next != state_reg);
    assign timer_en    = ((state_reg == FETCH) || (state_reg == MEM)) && !mem_ready;

    mc_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FETCH;
            timeout_err_reg <= 1'b0;
            retired_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
            if (retire) begin
                retired_reg <= retired_reg + RET_W'(1);
            end
        end
    end

    assign timeout_err = timeout_err_reg;
    assign retired     = retired_reg;

    always_comb begin
        state_next  = state_reg;
        retire      = 1'b0;
        timeout_hit = 1'b0;
        pc_w        = 1'b0;
        pc_w_cond   = 1'b0;
        pc_src      = 1'b0;
        iord        = 1'b0;
        mem_r       = 1'b0;
        mem_w       = 1'b0;
        ir_w        = 1'b0;
        reg_dst     = 1'b0;
        reg_w       = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRC_B_RT;
        alu_op      = ALU_SUB;
        illegal_op  = 1'b0;

        case (state_reg)
            FETCH: begin
                mem_r     = 1'b1;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_ADD;
                // A completing transfer beats an expiring wait on the same cycle.
                if (mem_ready) begin
                    ir_w       = 1'b1;
                    pc_w       = 1'b1;
                    state_next = DECODE;
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = HALT;
                end
            end
            DECODE: begin
                alu_src_b = SRC_B_IMM_SH2;
                alu_op    = ALU_ADD;
                if (is_alu_class(opcode)) begin
                    state_next = EXEC;
                end else if (is_mem_class(opcode)) begin
                    state_next = ADDR;
`ifdef MULTICYCLE_CONTROL_BRANCH_EN
                end else if (opcode == OP_BEQ) begin
                    state_next = BRANCH;
`endif
                end else begin
                    illegal_op = 1'b1;
                    state_next = FETCH;
                end
            end
            EXEC: begin
                alu_src_a = 1'b1;
                case (opcode)
                    OP_RTYPE: begin
                        alu_src_b = SRC_B_RT;
                        alu_op    = ALU_FUNCT;
                    end
                    OP_ORI: begin
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_OR;
                    end
                    default: begin
                        alu_src_b = SRC_B_IMM;
                        alu_op    = ALU_ADD;
                    end
                endcase
                state_next = ALU_WB;
            end
            ALU_WB: begin
                reg_w      = 1'b1;
                reg_dst    = (opcode == OP_RTYPE);
                retire     = 1'b1;
                state_next = FETCH;
            end
            ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_ADD;
                state_next = MEM;
            end
            MEM: begin
                iord  = 1'b1;
                mem_r = (opcode == OP_LW);
                mem_w = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_LW) begin
                        state_next = LW_WB;
                    end else begin
                        retire     = (opcode == OP_SW);
                        state_next = FETCH;
                    end
                end else if (wait_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = HALT;
                end
            end
            LW_WB: begin
                reg_w      = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
`ifdef MULTICYCLE_CONTROL_BRANCH_EN
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_RT;
                alu_op     = ALU_SUB;
                pc_w_cond  = 1'b1;
                pc_src     = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
`endif
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // While reset is held nothing may reach the datapath or memory.
        if (!rst_n) begin
            retire      = 1'b0;
            timeout_hit = 1'b0;
            pc_w        = 1'b0;
            pc_w_cond   = 1'b0;
            pc_src      = 1'b0;
            iord        = 1'b0;
            mem_r       = 1'b0;
            mem_w       = 1'b0;
            ir_w        = 1'b0;
            reg_dst     = 1'b0;
            reg_w       = 1'b0;
            mem_to_reg  = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = SRC_B_RT;
            alu_op      = ALU_SUB;
            illegal_op  = 1'b0;
        end
    end

endmodule
